// File: rtl/viterbi_pkg.sv
// Shared definitions for the K=3 rate-1/2 Viterbi decoder slice.
// Holds the trellis state type, branch-metric width, ACS control FSM
// encoding and the predecessor table used by the add-compare-select stage.
package viterbi_pkg;

    typedef logic [1:0] state_t;

    localparam int BM_W       = 2;
    localparam int NUM_STATES = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } fsm_e;

    // Predecessors of each next state: the lower-index one wins ties (dec=0).
    //   s0 <- s0,s1   s1 <- s2,s3   s2 <- s0,s1   s3 <- s2,s3
    localparam state_t PRED_LO [NUM_STATES] = '{2'd0, 2'd2, 2'd0, 2'd2};
    localparam state_t PRED_HI [NUM_STATES] = '{2'd1, 2'd3, 2'd1, 2'd3};

endpackage

// File: rtl/acs_butterfly_cell.sv
// Single add-compare-select for one next trellis state.
// Ports:
//   pm_a, pm_b : path metrics of the lower / higher index predecessor
//   bm_a, bm_b : branch metrics on the two incoming edges
//   pm_sel     : surviving candidate, one bit wider so the add never wraps
//   dec        : 0 when the lower-index predecessor survives (also on ties)
module acs_butterfly_cell
    import viterbi_pkg::*;
#(
    parameter int PM_W = 6
) (
    input  logic [PM_W-1:0] pm_a,
    input  logic [PM_W-1:0] pm_b,
    input  logic [BM_W-1:0] bm_a,
    input  logic [BM_W-1:0] bm_b,
    output logic [PM_W:0]   pm_sel,
    output logic            dec
);

    logic [PM_W:0] cand_a_s;
    logic [PM_W:0] cand_b_s;

    assign cand_a_s = {1'b0, pm_a} + {{(PM_W + 1 - BM_W){1'b0}}, bm_a};
    assign cand_b_s = {1'b0, pm_b} + {{(PM_W + 1 - BM_W){1'b0}}, bm_b};

    // Compare and select; strict less-than keeps ties on the lower index.
    always_comb begin
        pm_sel = cand_a_s;
        dec    = 1'b0;
        if (cand_b_s < cand_a_s) begin
            pm_sel = cand_b_s;
            dec    = 1'b1;
        end else begin
            pm_sel = cand_a_s;
            dec    = 1'b0;
        end
    end

endmodule

// File: rtl/viterbi_acs.sv
// Add-compare-select stage with frame sequencing and metric normalisation.
// Ports:
//   clk_i, rst_ni          : clock (rising edge), async active-low reset
//   start_i                : begin a frame (reinitialise metrics and counter)
//   bm_valid_i, bm_*_i     : eight 2-bit branch metrics from the BMU
//   dec_o, dec_valid_o     : survivor decision per next state, step strobe
//   pm0_o..pm3_o           : registered, normalised, saturated path metrics
//   best_state_o           : argmin of the metrics (ties to lowest index)
//   step_cnt_o             : accepted steps in the current frame
//   busy_o, frame_done_o   : frame in progress, one-cycle end-of-frame pulse
module viterbi_acs
    import viterbi_pkg::*;
#(
    parameter int PM_W      = 6,
    parameter int INIT_PM   = 16,
    parameter int FRAME_LEN = 16,
    parameter int CNT_W     = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             bm_valid_i,
    input  logic [1:0]       bm_s0_s0_i,
    input  logic [1:0]       bm_s0_s2_i,
    input  logic [1:0]       bm_s1_s0_i,
    input  logic [1:0]       bm_s1_s2_i,
    input  logic [1:0]       bm_s2_s1_i,
    input  logic [1:0]       bm_s2_s3_i,
    input  logic [1:0]       bm_s3_s1_i,
    input  logic [1:0]       bm_s3_s3_i,
    output logic [3:0]       dec_o,
    output logic             dec_valid_o,
    output logic [PM_W-1:0]  pm0_o,
    output logic [PM_W-1:0]  pm1_o,
    output logic [PM_W-1:0]  pm2_o,
    output logic [PM_W-1:0]  pm3_o,
    output logic [1:0]       best_state_o,
    output logic [CNT_W-1:0] step_cnt_o,
    output logic             busy_o,
    output logic             frame_done_o
);

    localparam logic [PM_W:0]    PM_MAX    = {1'b0, {PM_W{1'b1}}};
    localparam logic [PM_W-1:0]  PM_ZERO   = {PM_W{1'b0}};
    localparam logic [PM_W-1:0]  INIT_PM_V = PM_W'(INIT_PM);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME_LEN - 1);

    fsm_e                  state_r;
    logic [PM_W-1:0]       pm_r [NUM_STATES];
    logic [NUM_STATES-1:0] dec_r;
    logic                  dec_valid_r;
    state_t                best_r;
    logic [CNT_W-1:0]      cnt_r;
    logic                  busy_r;
    logic                  frame_done_r;

    logic [BM_W-1:0]       bm_lo_s [NUM_STATES];
    logic [BM_W-1:0]       bm_hi_s [NUM_STATES];
    logic [PM_W:0]         sel_s [NUM_STATES];
    logic [NUM_STATES-1:0] dec_s;
    logic [PM_W:0]         min_s;
    logic [PM_W-1:0]       next_pm_s [NUM_STATES];
    state_t                best_next_s;
    logic [PM_W-1:0]       best_pm_s;

    // Clamp a normalised metric into PM_W bits.
    function automatic logic [PM_W-1:0] sat_pm(input logic [PM_W:0] v);
        if (v > PM_MAX) begin
            sat_pm = {PM_W{1'b1}};
        end else begin
            sat_pm = v[PM_W-1:0];
        end
    endfunction

    // Route BMU ports onto the (next state, predecessor) edges.
    assign bm_lo_s[0] = bm_s0_s0_i;
    assign bm_hi_s[0] = bm_s1_s0_i;
    assign bm_lo_s[1] = bm_s2_s1_i;
    assign bm_hi_s[1] = bm_s3_s1_i;
    assign bm_lo_s[2] = bm_s0_s2_i;
    assign bm_hi_s[2] = bm_s1_s2_i;
    assign bm_lo_s[3] = bm_s2_s3_i;
    assign bm_hi_s[3] = bm_s3_s3_i;

    for (genvar n = 0; n < NUM_STATES; n++) begin : g_acs
        acs_butterfly_cell #(.PM_W(PM_W)) u_cell (
            .pm_a   (pm_r[PRED_LO[n]]),
            .pm_b   (pm_r[PRED_HI[n]]),
            .bm_a   (bm_lo_s[n]),
            .bm_b   (bm_hi_s[n]),
            .pm_sel (sel_s[n]),
            .dec    (dec_s[n])
        );
    end

    // Minimum of the four survivors, used as the normalisation offset.
    always_comb begin
        min_s = sel_s[0];
        for (int n = 1; n < NUM_STATES; n++) begin
            if (sel_s[n] < min_s) begin
                min_s = sel_s[n];
            end else begin
                min_s = min_s;
            end
        end
    end

    // Normalise so the best metric is zero, then saturate.
    always_comb begin
        for (int n = 0; n < NUM_STATES; n++) begin
            next_pm_s[n] = sat_pm(sel_s[n] - min_s);
        end
    end

    // Argmin of the next metrics; strict compare gives ties to the lowest index.
    always_comb begin
        best_next_s = 2'd0;
        best_pm_s   = next_pm_s[0];
        for (int n = 1; n < NUM_STATES; n++) begin
            if (next_pm_s[n] < best_pm_s) begin
                best_next_s = state_t'(n);
                best_pm_s   = next_pm_s[n];
            end else begin
                best_next_s = best_next_s;
                best_pm_s   = best_pm_s;
            end
        end
    end

    // Frame FSM plus all registered outputs; start_i overrides any step.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r      <= IDLE;
            for (int n = 0; n < NUM_STATES; n++) begin
                pm_r[n] <= (n == 0) ? PM_ZERO : INIT_PM_V;
            end
            dec_r        <= 4'b0000;
            dec_valid_r  <= 1'b0;
            best_r       <= 2'd0;
            cnt_r        <= {CNT_W{1'b0}};
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            dec_valid_r  <= 1'b0;
            frame_done_r <= 1'b0;
            if (start_i) begin
                state_r <= ACTIVE;
                for (int n = 0; n < NUM_STATES; n++) begin
                    pm_r[n] <= (n == 0) ? PM_ZERO : INIT_PM_V;
                end
                best_r  <= 2'd0;
                cnt_r   <= {CNT_W{1'b0}};
                busy_r  <= 1'b1;
            end else begin
                case (state_r)
                    IDLE: begin
                        state_r <= IDLE;
                    end
                    ACTIVE: begin
                        if (bm_valid_i) begin
                            pm_r        <= next_pm_s;
                            dec_r       <= dec_s;
                            dec_valid_r <= 1'b1;
                            best_r      <= best_next_s;
                            cnt_r       <= cnt_r + CNT_ONE;
                            if (cnt_r == CNT_LAST) begin
                                state_r      <= DONE;
                                busy_r       <= 1'b0;
                                frame_done_r <= 1'b1;
                            end else begin
                                state_r <= ACTIVE;
                            end
                        end else begin
                            state_r <= ACTIVE;
                        end
                    end
                    DONE: begin
                        state_r <= IDLE;
                    end
                    default: begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign pm0_o        = pm_r[0];
    assign pm1_o        = pm_r[1];
    assign pm2_o        = pm_r[2];
    assign pm3_o        = pm_r[3];
    assign dec_o        = dec_r;
    assign dec_valid_o  = dec_valid_r;
    assign best_state_o = best_r;
    assign step_cnt_o   = cnt_r;
    assign busy_o       = busy_r;
    assign frame_done_o = frame_done_r;

endmodule

// File: tb/tb_viterbi_acs.sv
// Bench for viterbi_acs: two instances (default widths, and PM_W=4/INIT_PM=15)
// share one directed stimulus stream; a trellis-level model predicts every
// output each cycle, and hand-computed literals pin the model.
module tb_viterbi_acs;

    localparam logic [15:0] IN00 = 16'h2855; // bm 0,2,2,0,1,1,1,1
    localparam logic [15:0] IN11 = 16'h8255; // bm 2,0,0,2,1,1,1,1
    localparam logic [15:0] IN01 = 16'h5582; // bm 1,1,1,1,2,0,0,2
    localparam logic [15:0] IN10 = 16'h5528; // bm 1,1,1,1,0,2,2,0
    localparam logic [15:0] BMAX = 16'hFFFF;

    logic        clk = 1'b0;
    logic        rst_n, start, bm_valid;
    logic [15:0] bm_vec;
    logic [1:0]  b00, b02, b10, b12, b21, b23, b31, b33;

    logic [3:0] dec_a, dec_b;
    logic       dv_a, dv_b, busy_a, busy_b, fd_a, fd_b;
    logic [5:0] pa0, pa1, pa2, pa3;
    logic [3:0] pb0, pb1, pb2, pb3;
    logic [1:0] best_a, best_b;
    logic [7:0] cnt_a, cnt_b;

    int checks = 0;
    int failures = 0;
    int fd_seen = 0;

    // model state
    int exp_pm [2][4];
    int exp_best [2];
    int exp_dec [2];
    int exp_dv, exp_cnt, exp_busy, exp_fd;
    bit m_active;
    int bm_t [4][4];
    int pm_max [2] = '{63, 15};
    int pm_init [2] = '{16, 15};
    logic [15:0] pat [5];

    always #5 clk = ~clk;

    assign {b00, b02, b10, b12, b21, b23, b31, b33} = bm_vec;

    viterbi_acs dut_a (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .bm_valid_i(bm_valid),
        .bm_s0_s0_i(b00), .bm_s0_s2_i(b02), .bm_s1_s0_i(b10), .bm_s1_s2_i(b12),
        .bm_s2_s1_i(b21), .bm_s2_s3_i(b23), .bm_s3_s1_i(b31), .bm_s3_s3_i(b33),
        .dec_o(dec_a), .dec_valid_o(dv_a),
        .pm0_o(pa0), .pm1_o(pa1), .pm2_o(pa2), .pm3_o(pa3),
        .best_state_o(best_a), .step_cnt_o(cnt_a), .busy_o(busy_a), .frame_done_o(fd_a)
    );

    viterbi_acs #(.PM_W(4), .INIT_PM(15)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .bm_valid_i(bm_valid),
        .bm_s0_s0_i(b00), .bm_s0_s2_i(b02), .bm_s1_s0_i(b10), .bm_s1_s2_i(b12),
        .bm_s2_s1_i(b21), .bm_s2_s3_i(b23), .bm_s3_s1_i(b31), .bm_s3_s3_i(b33),
        .dec_o(dec_b), .dec_valid_o(dv_b),
        .pm0_o(pb0), .pm1_o(pb1), .pm2_o(pb2), .pm3_o(pb3),
        .best_state_o(best_b), .step_cnt_o(cnt_b), .busy_o(busy_b), .frame_done_o(fd_b)
    );

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic model_init(input int k);
        exp_pm[k][0] = 0;
        for (int n = 1; n < 4; n++) exp_pm[k][n] = pm_init[k];
        exp_best[k] = 0;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            model_init(k);
            exp_dec[k] = 0;
        end
        exp_dv = 0; exp_cnt = 0; exp_busy = 0; exp_fd = 0; m_active = 1'b0;
    endtask

    // One trellis step: next n is reached from predecessors 2*(n%2) and 2*(n%2)+1.
    task automatic model_step(input int k);
        int sel [4];
        int d [4];
        int lo, hi, ca, cb, mn, v, bp;
        for (int n = 0; n < 4; n++) begin
            lo = (n % 2) * 2;
            hi = lo + 1;
            ca = exp_pm[k][lo] + bm_t[lo][n];
            cb = exp_pm[k][hi] + bm_t[hi][n];
            if (cb < ca) begin sel[n] = cb; d[n] = 1; end
            else begin sel[n] = ca; d[n] = 0; end
        end
        mn = sel[0];
        for (int n = 1; n < 4; n++) if (sel[n] < mn) mn = sel[n];
        exp_dec[k] = 0;
        for (int n = 0; n < 4; n++) begin
            v = sel[n] - mn;
            exp_pm[k][n] = (v > pm_max[k]) ? pm_max[k] : v;
            exp_dec[k] += d[n] << n;
        end
        exp_best[k] = 0;
        bp = exp_pm[k][0];
        for (int n = 1; n < 4; n++) if (exp_pm[k][n] < bp) begin
            bp = exp_pm[k][n];
            exp_best[k] = n;
        end
    endtask

    // Model advances on the same edges the DUT sees.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            exp_dv = 0;
            exp_fd = 0;
            bm_t[0][0] = int'(b00); bm_t[0][2] = int'(b02);
            bm_t[1][0] = int'(b10); bm_t[1][2] = int'(b12);
            bm_t[2][1] = int'(b21); bm_t[2][3] = int'(b23);
            bm_t[3][1] = int'(b31); bm_t[3][3] = int'(b33);
            if (start) begin
                m_active = 1'b1; exp_busy = 1; exp_cnt = 0;
                model_init(0); model_init(1);
            end else if (m_active && bm_valid) begin
                model_step(0); model_step(1);
                exp_dv = 1;
                exp_cnt++;
                if (exp_cnt == 16) begin
                    m_active = 1'b0; exp_busy = 0; exp_fd = 1;
                end
            end
        end
    end

    task automatic cmp_inst(input string t, input int k, input int p0, input int p1,
                            input int p2, input int p3, input int best, input int dec,
                            input int dv, input int cnt, input int busy, input int fd);
        chk({t, "_pm0"}, p0, exp_pm[k][0]);
        chk({t, "_pm1"}, p1, exp_pm[k][1]);
        chk({t, "_pm2"}, p2, exp_pm[k][2]);
        chk({t, "_pm3"}, p3, exp_pm[k][3]);
        chk({t, "_best"}, best, exp_best[k]);
        chk({t, "_dec"}, dec, exp_dec[k]);
        chk({t, "_dec_valid"}, dv, exp_dv);
        chk({t, "_step_cnt"}, cnt, exp_cnt);
        chk({t, "_busy"}, busy, exp_busy);
        chk({t, "_frame_done"}, fd, exp_fd);
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        cmp_inst("a", 0, int'(pa0), int'(pa1), int'(pa2), int'(pa3), int'(best_a),
                 int'(dec_a), int'(dv_a), int'(cnt_a), int'(busy_a), int'(fd_a));
        cmp_inst("b", 1, int'(pb0), int'(pb1), int'(pb2), int'(pb3), int'(best_b),
                 int'(dec_b), int'(dv_b), int'(cnt_b), int'(busy_b), int'(fd_b));
        if (fd_a) fd_seen++;
    end

    task automatic cyc(input logic st, input logic v, input logic [15:0] bm);
        start = st;
        bm_valid = v;
        bm_vec = bm;
        @(negedge clk);
    endtask

    task automatic lit_pm_a(input string t, input int e0, input int e1, input int e2, input int e3);
        chk({t, "_pm0"}, int'(pa0), e0);
        chk({t, "_pm1"}, int'(pa1), e1);
        chk({t, "_pm2"}, int'(pa2), e2);
        chk({t, "_pm3"}, int'(pa3), e3);
    endtask

    initial begin
        int mx, mn;
        pat = '{IN00, IN11, IN01, IN10, 16'hC3E1};
        rst_n = 1'b0; start = 1'b0; bm_valid = 1'b0; bm_vec = 16'h0000;
        repeat (2) @(negedge clk);
        lit_pm_a("rst", 0, 16, 16, 16);
        chk("rst_cnt", int'(cnt_a), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_dv", int'(dv_a), 0);
        rst_n = 1'b1;

        // two steps of input 00
        cyc(1'b1, 1'b0, IN00);
        chk("start_busy", int'(busy_a), 1);
        cyc(1'b0, 1'b1, IN00);
        lit_pm_a("s1", 0, 17, 2, 17);
        chk("s1_dec", int'(dec_a), 0);
        chk("s1_best", int'(best_a), 0);
        chk("s1_dv", int'(dv_a), 1);
        chk("s1_b_pm1_sat", int'(pb1), 15);
        chk("s1_b_pm2", int'(pb2), 2);
        cyc(1'b0, 1'b1, IN00);
        lit_pm_a("s2", 0, 3, 2, 3);
        chk("s2_dec", int'(dec_a), 0);
        chk("s2_cnt", int'(cnt_a), 2);
        cyc(1'b0, 1'b0, IN00);
        chk("gap_dv", int'(dv_a), 0);

        // one step of input 11
        cyc(1'b1, 1'b0, IN00);
        cyc(1'b0, 1'b1, IN11);
        lit_pm_a("i11", 2, 17, 0, 17);
        chk("i11_best", int'(best_a), 2);
        chk("i11_dec", int'(dec_a), 0);
        chk("i11_dv", int'(dv_a), 1);
        cyc(1'b0, 1'b0, IN11);
        chk("i11_dv_drop", int'(dv_a), 0);

        // full frame with gaps
        fd_seen = 0;
        cyc(1'b1, 1'b0, IN00);
        for (int i = 0; i < 31; i++) cyc(1'b0, (i % 2) == 0, pat[i % 5]);
        chk("frame_cnt", int'(cnt_a), 16);
        chk("frame_done", int'(fd_a), 1);
        chk("frame_busy", int'(busy_a), 0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, pat[i]);
        chk("post_done", int'(fd_a), 0);
        chk("post_cnt", int'(cnt_a), 16);
        chk("post_dv", int'(dv_a), 0);
        chk("frame_done_pulses", fd_seen, 1);

        // start colliding with a valid step
        cyc(1'b1, 1'b0, IN00);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, pat[i + 1]);
        cyc(1'b1, 1'b1, IN00);
        lit_pm_a("restart", 0, 16, 16, 16);
        chk("restart_cnt", int'(cnt_a), 0);
        chk("restart_dv", int'(dv_a), 0);
        cyc(1'b0, 1'b1, IN11);
        lit_pm_a("restart_step", 2, 17, 0, 17);
        chk("restart_step_cnt", int'(cnt_a), 1);

        // saturation stress on the narrow instance
        cyc(1'b1, 1'b0, BMAX);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b1, BMAX);
            if (i == 0) begin
                chk("sat_b_pm1", int'(pb1), 15);
                chk("sat_b_pm2", int'(pb2), 0);
            end
            mx = int'(pb0); mn = int'(pb0);
            if (int'(pb1) > mx) mx = int'(pb1);
            if (int'(pb2) > mx) mx = int'(pb2);
            if (int'(pb3) > mx) mx = int'(pb3);
            if (int'(pb1) < mn) mn = int'(pb1);
            if (int'(pb2) < mn) mn = int'(pb2);
            if (int'(pb3) < mn) mn = int'(pb3);
            chk("sat_b_max_le_15", int'(mx <= 15), 1);
            chk("sat_b_min_zero", mn, 0);
        end

        // async reset mid-frame
        fd_seen = 0;
        cyc(1'b1, 1'b0, IN00);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, pat[i]);
        bm_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        lit_pm_a("arst", 0, 16, 16, 16);
        chk("arst_cnt", int'(cnt_a), 0);
        chk("arst_busy", int'(busy_a), 0);
        chk("arst_best", int'(best_a), 0);
        chk("arst_dec", int'(dec_a), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, 1'b1, IN00);
        cyc(1'b0, 1'b1, IN11);
        chk("arst_idle_dv", int'(dv_a), 0);
        chk("arst_idle_cnt", int'(cnt_a), 0);
        chk("arst_no_done", fd_seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/viterbi_acs.md
Name: viterbi_acs

Overview:
- Add-Compare-Select stage of the K=3, rate-1/2 hard-decision Viterbi decoder.
- Sits directly downstream of the BMU. Each accepted step, it consumes the eight 2-bit branch metrics and updates four registered path metrics.
- Emits one survivor decision bit per state to the traceback/survivor memory, plus the current best state.
- Includes frame sequencing (start, step count, frame-done) and path-metric normalization.

Parameters:
- PM_W, 6, path-metric width in bits; unsigned; arithmetic saturates at 2^PM_W-1.
- INIT_PM, 16, initial metric for states s1..s3 at frame start (s0 starts at 0); must be <= 2^PM_W-1.
- FRAME_LEN, 16, number of accepted ACS steps per frame; >= 2.
- CNT_W, 8, width of step counter; 2^CNT_W > FRAME_LEN.

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  begin new frame; reinitialises metrics and counter
- bm_valid_i  in  1  branch metrics valid this cycle
- bm_s0_s0_i, bm_s0_s2_i, bm_s1_s0_i, bm_s1_s2_i  in  2 each  BMU branch metrics
- bm_s2_s1_i, bm_s2_s3_i, bm_s3_s1_i, bm_s3_s3_i  in  2 each  BMU branch metrics
- dec_o  out  4  survivor decision per next state (bit n = state n)
- dec_valid_o  out  1  dec_o valid, one pulse per accepted step
- pm0_o, pm1_o, pm2_o, pm3_o  out  PM_W each  registered path metrics
- best_state_o  out  2  argmin of pm0..3_o; ties go to the lowest index
- step_cnt_o  out  CNT_W  accepted steps in current frame
- busy_o  out  1  high in ACTIVE
- frame_done_o  out  1  one-cycle pulse after last step

Behaviour:
- Reset (async, rst_ni=0):
  - FSM goes to IDLE.
  - pm0=0; pm1..pm3=INIT_PM.
  - dec_o=0, dec_valid_o=0, best_state_o=0, step_cnt_o=0, busy_o=0, frame_done_o=0.
- FSM states are IDLE, ACTIVE, DONE.
  - IDLE: bm_valid_i ignored. start_i loads initial metrics, clears the counter and moves to ACTIVE.
  - ACTIVE: each cycle with bm_valid_i=1 performs one ACS step and increments step_cnt. On the step where step_cnt reaches FRAME_LEN, move to DONE.
  - DONE: frame_done_o=1 for exactly one cycle, then IDLE. Metrics and best_state_o are held for traceback.
  - start_i in any state, including mid-frame or in DONE: reinitialise and enter ACTIVE. start_i has priority over a simultaneous bm_valid_i; that sample is dropped with no dec_valid_o.
- Trellis (next <- predecessors):
  - s0 <- s0 via bm_s0_s0, s1 via bm_s1_s0
  - s1 <- s2 via bm_s2_s1, s3 via bm_s3_s1
  - s2 <- s0 via bm_s0_s2, s1 via bm_s1_s2
  - s3 <- s2 via bm_s2_s3, s3 via bm_s3_s3
- ACS step:
  - Candidate = pm_pred + bm, computed at PM_W+1 bits.
  - Select the smaller candidate. dec bit = 0 if the lower-index predecessor wins; ties choose the lower index (dec=0).
  - Normalise: subtract the minimum of the four selected metrics from all four.
  - Saturate the result to 2^PM_W-1.
- Latency: dec_o, dec_valid_o, pm*_o and step_cnt_o update on the clock edge that accepts the step (one-cycle registered). best_state_o is derived from the next metrics and updates on the same edge.
- Outputs hold between steps. dec_valid_o is low in any cycle without an accepted step.
- A reset asserted mid-frame aborts the frame immediately; no frame_done_o is produced.

Decomposition:
- Shared package viterbi_pkg holds:
  - state typedef (2-bit)
  - branch-metric width constant BM_W=2
  - FSM enum {IDLE, ACTIVE, DONE}
  - trellis predecessor table constants
- One sub-module, acs_butterfly_cell: a single add-compare-select for one next state. Inputs are two metrics and two branch metrics; outputs are the selected metric and the decision bit. Instantiated four times.
- Normalization, saturation, argmin and the FSM stay in the top module.

Test Plan:
- Reset then start_i, two steps of all-zero metrics (input 00: bm 0,2,2,0,1,1,1,1) -> step1 pm=(0,17,2,17), dec=0000, best=0; step2 pm=(0,3,2,3), dec=0000, best=0.
- start_i, one step with input 11 (bm 2,0,0,2,1,1,1,1) -> pm=(2,17,0,17), best_state_o=2, dec=0000, dec_valid_o one pulse.
- Full frame of FRAME_LEN=16 valid steps with gaps (bm_valid_i toggled) -> step_cnt_o reaches 16, frame_done_o pulses exactly once, busy_o drops, and bm_valid_i afterwards is ignored.
- start_i asserted together with bm_valid_i at step 5 -> metrics back to (0,16,16,16), step_cnt_o=0, no dec_valid_o that cycle.
- PM_W=4, INIT_PM=15 with repeated max metrics -> all pm*_o <= 15, no wrap, minimum always 0 after normalization.
- rst_ni pulsed low asynchronously mid-frame (between clock edges) -> outputs return to reset values immediately, and frame_done_o never asserts.
